// File: rtl/tick_period_meter.sv
// ---------------------------------------------------------------------------
// tick_period_meter
//
// Purpose:
//   Receive-side companion to the free_running tick generator. Measures the
//   spacing between consecutive single-cycle ticks and reports it in the same
//   encoding the generator is programmed with (cycles between ticks - 1).
//   Declares lock once the same spacing has repeated LOCK_CNT times after the
//   reference interval. Flags spacing mismatches while locked, and flags a
//   timeout when no tick arrives within 2^CNT_W cycles.
//
// Parameters:
//   CNT_W        width of the gap counter and of period
//   LOCK_CNT     matching intervals needed for lock (1..15)
//
// Ports:
//   clk          sole clock, rising edge
//   reset        asynchronous active-high reset, clears all state
//   enable       synchronous enable; low forces the reset values next edge
//   tick_in      tick stream, one tick per edge where it is high
//   period       last measured interval, in cycles minus one
//   period_valid one-cycle pulse, period was updated on this edge
//   locked       high while in the LOCKED state
//   mismatch     one-cycle pulse, tick in LOCKED with a different spacing
//   timeout      one-cycle pulse, no tick within 2^CNT_W cycles
// ---------------------------------------------------------------------------
module tick_period_meter #(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             tick_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             mismatch,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    TRACK,
    LOCKED
  } state_t;

  localparam logic [CNT_W-1:0] GAP_MAX    = '1;
  localparam logic [3:0]       LOCK_CNT_V = 4'(LOCK_CNT);

  state_t           state;
  logic [CNT_W-1:0] gap;
  logic [3:0]       match_cnt;

  logic [3:0] match_next;
  logic       gap_expired;
  logic       gap_equal;

  // The gap counter saturates at GAP_MAX; reaching it with no tick means the
  // tick source has gone quiet for 2^CNT_W cycles. IDLE holds gap at zero,
  // so the expiry is only meaningful once a first tick has been seen.
  // gap_equal compares the interval just completed against the reference
  // interval held in period.
  assign match_next  = match_cnt + 4'd1;
  assign gap_expired = (gap == GAP_MAX) && !tick_in && (state != IDLE);
  assign gap_equal   = (gap == period);

  // Single state machine owning the gap counter, the match counter and all
  // registered outputs. Pulse outputs default low every enabled edge and are
  // raised only on the edge of their event, which makes them exactly one
  // cycle wide. A tick is handled before a timeout check, so a tick on the
  // would-be timeout edge is measured as period = 2^CNT_W - 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      gap          <= '0;
      match_cnt    <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      mismatch     <= 1'b0;
      timeout      <= 1'b0;
    end else if (!enable) begin
      state        <= IDLE;
      gap          <= '0;
      match_cnt    <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      mismatch     <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      mismatch     <= 1'b0;
      timeout      <= 1'b0;

      case (state)
        IDLE: begin
          gap <= '0;
          if (tick_in) begin
            state <= ACQUIRE;
          end
        end

        ACQUIRE: begin
          if (tick_in) begin
            gap          <= '0;
            period       <= gap;
            period_valid <= 1'b1;
            match_cnt    <= '0;
            state        <= TRACK;
          end else if (gap_expired) begin
            gap       <= '0;
            match_cnt <= '0;
            locked    <= 1'b0;
            timeout   <= 1'b1;
            state     <= IDLE;
          end else begin
            gap <= gap + 1'b1;
          end
        end

        TRACK: begin
          if (tick_in) begin
            gap          <= '0;
            period       <= gap;
            period_valid <= 1'b1;
            if (gap_equal) begin
              match_cnt <= match_next;
              if (match_next == LOCK_CNT_V) begin
                locked <= 1'b1;
                state  <= LOCKED;
              end
            end else begin
              // A different spacing becomes the new reference interval.
              match_cnt <= '0;
            end
          end else if (gap_expired) begin
            gap       <= '0;
            match_cnt <= '0;
            locked    <= 1'b0;
            timeout   <= 1'b1;
            state     <= IDLE;
          end else begin
            gap <= gap + 1'b1;
          end
        end

        LOCKED: begin
          if (tick_in) begin
            gap          <= '0;
            period_valid <= 1'b1;
            if (!gap_equal) begin
              period    <= gap;
              mismatch  <= 1'b1;
              match_cnt <= '0;
              locked    <= 1'b0;
              state     <= TRACK;
            end
          end else if (gap_expired) begin
            gap       <= '0;
            match_cnt <= '0;
            locked    <= 1'b0;
            timeout   <= 1'b1;
            state     <= IDLE;
          end else begin
            gap <= gap + 1'b1;
          end
        end

        default: begin
          gap       <= '0;
          match_cnt <= '0;
          locked    <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_period_meter.sv
// ---------------------------------------------------------------------------
// tb_tick_period_meter
//
// Directed bench for tick_period_meter with default parameters (CNT_W=8,
// LOCK_CNT=4). Expected values are hand-computed from the tick spacing:
// N idle cycles between ticks give period = N.
// ---------------------------------------------------------------------------
module tb_tick_period_meter;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       tick_in;
  logic [7:0] period;
  logic       period_valid;
  logic       locked;
  logic       mismatch;
  logic       timeout;

  int vectors;
  int miscompares;

  tick_period_meter #(
    .CNT_W   (8),
    .LOCK_CNT(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .tick_in     (tick_in),
    .period      (period),
    .period_valid(period_valid),
    .locked      (locked),
    .mismatch    (mismatch),
    .timeout     (timeout)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every comparison and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Compares every output against its expected value.
  task automatic checkState(input string tag, input logic [7:0] exp_period,
                            input logic exp_valid, input logic exp_locked,
                            input logic exp_mismatch, input logic exp_timeout);
    checkOutput({tag, ".period"}, 32'(period), 32'(exp_period));
    checkOutput({tag, ".period_valid"}, 32'(period_valid), 32'(exp_valid));
    checkOutput({tag, ".locked"}, 32'(locked), 32'(exp_locked));
    checkOutput({tag, ".mismatch"}, 32'(mismatch), 32'(exp_mismatch));
    checkOutput({tag, ".timeout"}, 32'(timeout), 32'(exp_timeout));
  endtask

  // Drives tick_in for one edge and returns 1 ns after that edge, when the
  // registered outputs reflect it.
  task automatic applyStimulus(input logic t);
    tick_in = t;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0);
  endtask

  // Six ticks separated by 'zeros' idle cycles, starting from IDLE.
  // Tick 1 only enters ACQUIRE, ticks 2..6 report the period, tick 6 locks.
  task automatic acquireLock(input string tag, input int zeros,
                             input logic [7:0] init_period);
    for (int i = 1; i <= 6; i++) begin
      if (i > 1) idleCycles(zeros);
      applyStimulus(1'b1);
      checkState($sformatf("%s.t%0d", tag, i),
                 (i >= 2) ? 8'(zeros) : init_period,
                 (i >= 2), (i >= 6), 1'b0, 1'b0);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    enable      = 1'b1;
    tick_in     = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkState("reset", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // Generator count 9: tick every 10 cycles, lock at the 6th tick.
    acquireLock("gen9", 9, 8'd0);

    // One 13-cycle gap while locked: mismatch, then relock after four more.
    idleCycles(12);
    applyStimulus(1'b1);
    checkState("mm", 8'd12, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0);
    checkState("mm_after", 8'd12, 1'b0, 1'b0, 1'b0, 1'b0);
    idleCycles(11);
    for (int j = 1; j <= 4; j++) begin
      if (j > 1) idleCycles(12);
      applyStimulus(1'b1);
      checkState($sformatf("relock.t%0d", j), 8'd12, 1'b1, (j == 4),
                 1'b0, 1'b0);
    end

    // Async reset between edges while locked.
    #2;
    reset = 1'b1;
    #1;
    checkState("async_rst", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    reset = 1'b0;
    acquireLock("post_rst", 9, 8'd0);

    // Ticks stop while locked: timeout exactly 256 cycles after last tick.
    idleCycles(255);
    checkState("pre_to", 8'd9, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0);
    checkState("to", 8'd9, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0);
    checkState("to_after", 8'd9, 1'b0, 1'b0, 1'b0, 1'b0);

    // Continuous ticks from IDLE: period 0, lock after 6 ticks.
    acquireLock("cont", 0, 8'd9);

    // Tick exactly at gap=255 while locked at 0: measured, not a timeout.
    idleCycles(255);
    applyStimulus(1'b1);
    checkState("gap255", 8'd255, 1'b1, 1'b0, 1'b1, 1'b0);

    // Enable low for 3 cycles during TRACK; tick on the first edge ignored.
    enable = 1'b0;
    applyStimulus(1'b1);
    checkState("dis1", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0);
    checkState("dis2", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1);
    checkState("dis3", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    enable = 1'b1;
    applyStimulus(1'b1);
    checkState("reen.t1", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idleCycles(4);
    applyStimulus(1'b1);
    checkState("reen.t2", 8'd4, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
